fifo_wr_arb: RTL



---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arb_rr_pick2.sv | 13 +
 rtl/fifo_wr_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and
// default widths.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_BURST = 16;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arb_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the source that was not
// served last wins; otherwise the single requester wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       any
);

  assign any  = |req;
  assign pick = (&req) ? ~last : req[1];

endmodule : rr_pick2

// File: rtl/fifo_wr_arb.sv
// Burst-based round-robin arbiter muxing two valid/ready byte streams onto the
// single write port of the shared data FIFO.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int BURST = DEF_BURST,
  parameter int CW    = $clog2(BURST + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src0_valid,
  input  logic [DW-1:0] src0_data,
  output logic          src0_ready,
  input  logic          src1_valid,
  input  logic [DW-1:0] src1_data,
  output logic          src1_ready,
  input  logic          wrfull,
  output logic          wrreq,
  output logic [DW-1:0] data,
  output logic [1:0]    gnt
);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic granted, own_valid, xfer, burst_end, rel;
  logic pick, any;

  // While granted, last_q already equals the owner, so the same picker
  // resolves both the idle arbitration and the handover at release.
  rr_pick2 u_pick (
    .req  ({src1_valid, src0_valid}),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    granted    = 1'b0;
    own_valid  = 1'b0;
    data       = '0;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    case (state_q)
      ST_G0: begin
        granted    = 1'b1;
        own_valid  = src0_valid;
        data       = src0_data;
        src0_ready = rst_n & ~wrfull;
      end
      ST_G1: begin
        granted    = 1'b1;
        own_valid  = src1_valid;
        data       = src1_data;
        src1_ready = rst_n & ~wrfull;
      end
      default: ;
    endcase

    xfer      = rst_n & granted & own_valid & ~wrfull;
    burst_end = xfer & (cnt_q == CW'(BURST - 1));
    rel       = granted & (burst_end | ~own_valid);
    wrreq     = xfer;
    gnt       = {state_q == ST_G1, state_q == ST_G0};
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!granted || rel) begin
      if (any) begin
        state_d = pick ? ST_G1 : ST_G0;
        last_d  = pick;
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : fifo_wr_arb
